// File: rtl/des_lc_pkg.sv
// Shared definitions for the DES linear-approximation counter.
// Holds the controller state type and the fixed DES block width used
// by the datapath, the pair-stream interface and the parity primitive.
package des_lc_pkg;

    localparam int DES_BLOCK_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lc_state_e;

endpackage

// File: rtl/linear_approx_counter_if.sv
// Plaintext/ciphertext pair stream with a valid/ready handshake.
// Signals:
//   pair_valid  source has a pair on plaintext/ciphertext
//   pair_ready  sink accepts the pair this cycle
//   plaintext   sample plaintext block
//   ciphertext  sample ciphertext block
// master = pair source (DES core / pair generator), slave = counter.
interface linear_approx_counter_if #(
    parameter int DATA_WIDTH = des_lc_pkg::DES_BLOCK_WIDTH
);

    logic                  pair_valid;
    logic                  pair_ready;
    logic [DATA_WIDTH-1:0] plaintext;
    logic [DATA_WIDTH-1:0] ciphertext;

    modport master (
        output pair_valid,
        output plaintext,
        output ciphertext,
        input  pair_ready
    );

    modport slave (
        input  pair_valid,
        input  plaintext,
        input  ciphertext,
        output pair_ready
    );

endinterface

// File: rtl/linear_approx_counter_mask_xor.sv
// Masked parity primitive: parity = XOR of all bits of (data & mask).
// Ports:
//   data    block to reduce
//   mask    bit selection
//   parity  1 when an odd number of selected bits are set
module mask_xor #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    output logic             parity
);

    assign parity = ^(data & mask);

endmodule

// File: rtl/linear_approx_counter.sv
// Counts how many (plaintext, ciphertext) pairs of a batch satisfy the
// linear approximation parity(P & in_mask) ^ parity(C & out_mask) == 0,
// and reports the signed bias 2*count_zero - N once the batch is done.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, abort    begin batch (IDLE/DONE only) / cancel batch (RUN/DRAIN)
//   num_samples     batch size N, latched at an accepted start
//   in_mask         plaintext mask, latched at an accepted start
//   out_mask        ciphertext mask, latched at an accepted start
//   pair_if         pair stream (slave side)
//   busy, done      RUN/DRAIN indicator, DONE level
//   count_zero      pairs whose combined parity was 0
//   samples_seen    pairs accepted in the current batch
//   bias            signed 2*count_zero - N, valid while done
module linear_approx_counter
    import des_lc_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int DATA_WIDTH  = DES_BLOCK_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [COUNT_WIDTH-1:0]     num_samples,
    input  logic [DATA_WIDTH-1:0]      in_mask,
    input  logic [DATA_WIDTH-1:0]      out_mask,
    linear_approx_counter_if.slave     pair_if,
    output logic                       busy,
    output logic                       done,
    output logic [COUNT_WIDTH-1:0]     count_zero,
    output logic [COUNT_WIDTH-1:0]     samples_seen,
    output logic [COUNT_WIDTH:0]       bias
);

    lc_state_e              state_q, state_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH-1:0]  in_mask_q, in_mask_d;
    logic [DATA_WIDTH-1:0]  out_mask_q, out_mask_d;
    logic [COUNT_WIDTH-1:0] count_zero_q, count_zero_d;
    logic [COUNT_WIDTH-1:0] samples_seen_q, samples_seen_d;
    logic [COUNT_WIDTH:0]   bias_q, bias_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_par_q, s1_par_d;

    logic pair_ready;
    logic p_par;
    logic c_par;
    logic handshake;
    logic start_accept;
    logic last_sample;

    mask_xor #(.WIDTH(DATA_WIDTH)) u_p_parity (
        .data   (pair_if.plaintext),
        .mask   (in_mask_q),
        .parity (p_par)
    );

    mask_xor #(.WIDTH(DATA_WIDTH)) u_c_parity (
        .data   (pair_if.ciphertext),
        .mask   (out_mask_q),
        .parity (c_par)
    );

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign handshake    = pair_if.pair_valid && pair_ready;
    assign last_sample  = handshake && (samples_seen_q == (n_q - COUNT_WIDTH'(1)));

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Abort beats the last-sample transition so an
    // aborted batch never reaches DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_sample) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                if (!abort) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; pair_ready depends only on state, never on pair_valid.
    always_comb begin
        pair_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            RUN:     begin pair_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign pair_if.pair_ready = pair_ready;

    // Datapath next values: stage 1 captures the combined parity of an
    // accepted pair, stage 2 counts it one edge later. The bias is formed
    // from the count as it closes out of DRAIN.
    always_comb begin
        n_d            = n_q;
        in_mask_d      = in_mask_q;
        out_mask_d     = out_mask_q;
        count_zero_d   = count_zero_q;
        samples_seen_d = samples_seen_q;
        bias_d         = bias_q;
        s1_valid_d     = 1'b0;
        s1_par_d       = s1_par_q;
        if (start_accept) begin
            n_d            = num_samples;
            in_mask_d      = in_mask;
            out_mask_d     = out_mask;
            count_zero_d   = '0;
            samples_seen_d = '0;
            bias_d         = '0;
        end else begin
            if (s1_valid_q && !s1_par_q) begin
                count_zero_d = count_zero_q + COUNT_WIDTH'(1);
            end
            if (handshake && !abort) begin
                samples_seen_d = samples_seen_q + COUNT_WIDTH'(1);
                s1_par_d       = p_par ^ c_par;
                s1_valid_d     = 1'b1;
            end
            if ((state_q == DRAIN) && !abort) begin
                bias_d = {count_zero_d, 1'b0} - {1'b0, n_q};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q            <= '0;
            in_mask_q      <= '0;
            out_mask_q     <= '0;
            count_zero_q   <= '0;
            samples_seen_q <= '0;
            bias_q         <= '0;
            s1_valid_q     <= 1'b0;
            s1_par_q       <= 1'b0;
        end else begin
            n_q            <= n_d;
            in_mask_q      <= in_mask_d;
            out_mask_q     <= out_mask_d;
            count_zero_q   <= count_zero_d;
            samples_seen_q <= samples_seen_d;
            bias_q         <= bias_d;
            s1_valid_q     <= s1_valid_d;
            s1_par_q       <= s1_par_d;
        end
    end

    assign count_zero   = count_zero_q;
    assign samples_seen = samples_seen_q;
    assign bias         = bias_q;

endmodule

// File: doc/linear_approx_counter.md
Name: linear_approx_counter

Overview:
Sequences a batch of known (plaintext, ciphertext) pairs through two 64-bit masked-parity reductions for DES linear cryptanalysis. Per sample it evaluates parity(P & in_mask) ^ parity(C & out_mask) and counts the samples whose parity is 0. It also reports the signed bias 2*count - N. It sits between the pair-generation/DES core stream and the key-recovery logic; the host configures masks and N, pulses start, then reads results when done.

Parameters:
COUNT_WIDTH, 32, width of sample-count / zero-count registers (N up to 2^COUNT_WIDTH-1)
DATA_WIDTH, 64, block and mask width (fixed 64 for DES; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin batch; honoured only in IDLE or DONE
abort  in  1  cancel batch; honoured in RUN/DRAIN
num_samples  in  COUNT_WIDTH  N, latched at start
in_mask  in  64  plaintext mask, latched at start
out_mask  in  64  ciphertext mask, latched at start
pair_valid  in  1  plaintext/ciphertext pair present
pair_ready  out  1  block accepts pair this cycle
plaintext  in  64  sample plaintext
ciphertext  in  64  sample ciphertext
busy  out  1  high in RUN or DRAIN
done  out  1  high while in DONE (level)
count_zero  out  COUNT_WIDTH  samples with combined parity 0
samples_seen  out  COUNT_WIDTH  pairs accepted so far
bias  out  COUNT_WIDTH+1  signed 2*count_zero - N, valid when done

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0, internal regs 0.
- IDLE/DONE + start: latch N, in_mask, out_mask; clear count_zero, samples_seen, pipeline valid, bias. If N==0 -> DONE (done high next cycle, count 0, bias 0); else -> RUN.
- start in RUN/DRAIN ignored. Masks/N inputs ignored except at accepted start.
- RUN: pair_ready=1. Handshake = pair_valid & pair_ready. On handshake: samples_seen++, stage-1 register p = parity(plaintext & in_mask) ^ parity(ciphertext & out_mask), s1_valid=1; without handshake s1_valid=0.
- Stage 2: on s1_valid & p==0, count_zero++. Counting happens one edge after the stage-1 register.
- Last sample: handshake when samples_seen == N-1 -> state DRAIN (pair_ready 0 from the next cycle).
- DRAIN: one cycle; count updated at its closing edge; bias computed and registered the same edge; -> DONE.
- Latency: last handshake in cycle T -> done high from cycle T+2, with final count_zero/bias stable then.
- DONE: done=1, results held until next start or rst. start in DONE behaves as in IDLE, with results cleared at the start edge.
- abort in RUN/DRAIN: -> IDLE next edge; pair_ready drops; a pair handshaken in the same cycle is discarded; done never asserts; counters hold their partial values (not guaranteed meaningful). abort and start together in IDLE/DONE: start wins; abort elsewhere is ignored.
- pair_valid with pair_ready low: no effect; the source must hold data (valid/ready rules, no combinational path from pair_valid to pair_ready).
- Widths: count_zero <= N, so no overflow; bias = {count_zero,0} - {0,N} in COUNT_WIDTH+1 two's complement.
- rst mid-operation: immediate return to IDLE, all cleared, regardless of state.

Decomposition:
- Package des_lc_pkg: state enum (IDLE, RUN, DRAIN, DONE), DES_BLOCK_WIDTH=64 constant.
- Sub-module: instantiate the existing mask_xor parity primitive twice (plaintext/in_mask, ciphertext/out_mask); XOR the two results before the stage-1 register. FSM, counters and bias stay in this module.

Test Plan:
- N=4, in_mask=out_mask=64'h1, pairs (P,C) LSBs (0,0),(1,0),(1,1),(0,1), valid held high -> pair_ready high 4 cycles; done at last handshake+2; count_zero=2, samples_seen=4, bias=0.
- N=3, in_mask=64'hFFFF_FFFF_FFFF_FFFF, out_mask=0, P=64'h3, 64'h7, 64'h0 with valid gaps of 2 cycles -> count_zero=2, bias=+1; pair_ready stays high during gaps.
- N=0 start -> done high next cycle, count_zero=0, bias=0, pair_ready never asserts.
- N=8, abort after 3 handshakes -> IDLE next cycle, busy=0, done never high; restart with N=2 gives clean result (count cleared).
- rst asserted asynchronously mid-RUN (N=5, after 2 samples) -> all outputs 0 immediately, state IDLE; start with new masks works.
- start pulsed during RUN with a different N -> ignored; batch completes with the original N; start in DONE clears results and begins new batch.
